// File: rtl/batcharger_if.sv
// Signal bundle between the sense/control side and the charge-sequencing controller.
interface batcharger_if #(
  parameter int ADC_W = 10,
  parameter int SEL_W = 4
);
  logic             en;
  logic [SEL_W-1:0] sel;
  logic             adc_valid;
  logic [ADC_W-1:0] vbat;
  logic [ADC_W-1:0] ibat;
  logic [ADC_W-1:0] vtemp;
  logic [SEL_W:0]   iset;
  logic             cv_mode;
  logic             chg_on;
  logic             done;
  logic [1:0]       fault;
  logic [2:0]       state;

  modport master (
    output en, sel, adc_valid, vbat, ibat, vtemp,
    input  iset, cv_mode, chg_on, done, fault, state
  );

  modport slave (
    input  en, sel, adc_valid, vbat, ibat, vtemp,
    output iset, cv_mode, chg_on, done, fault, state
  );
endinterface

// File: rtl/batcharger_ctrl.sv
// Battery charge sequencer: trickle / constant-current / constant-voltage / done,
// with termination debounce, safety timer and temperature/timeout faults.
module batcharger_ctrl #(
  parameter int ADC_W   = 10,
  parameter int SEL_W   = 4,
  parameter int VPRE    = 300,
  parameter int VFLOAT  = 840,
  parameter int VRECHG  = 800,
  parameter int ITERM   = 20,
  parameter int TMIN    = 100,
  parameter int TMAX    = 900,
  parameter int NTERM   = 4,
  parameter int TMR_W   = 20,
  parameter int TIMEOUT = 1000000
) (
  input logic        clk,
  input logic        rst,
  batcharger_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRICKLE = 3'd1,
    S_CC      = 3'd2,
    S_CV      = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(NTERM + 1);

  localparam logic [1:0]       F_NONE = 2'b00;
  localparam logic [1:0]       F_TEMP = 2'b01;
  localparam logic [1:0]       F_TIME = 2'b10;
  localparam logic [ADC_W-1:0] VPRE_C   = ADC_W'(VPRE);
  localparam logic [ADC_W-1:0] VFLOAT_C = ADC_W'(VFLOAT);
  localparam logic [ADC_W-1:0] VRECHG_C = ADC_W'(VRECHG);
  localparam logic [ADC_W-1:0] ITERM_C  = ADC_W'(ITERM);
  localparam logic [ADC_W-1:0] TMIN_C   = ADC_W'(TMIN);
  localparam logic [ADC_W-1:0] TMAX_C   = ADC_W'(TMAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTERM - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  state_t           st_q, st_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [1:0]       flt_q, flt_n;
  logic [TMR_W-1:0] tmr_q, tmr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             charging;
  logic             temp_ok;
  logic             pre_chg;

  // Current setpoint for a given state and latched capacity select.
  function automatic logic [SEL_W:0] iset_of(input state_t s, input logic [SEL_W-1:0] sq);
    logic [SEL_W:0] full;
    logic [SEL_W:0] quarter;
    full    = {1'b0, sq} + (SEL_W+1)'(1);
    quarter = full >> 2;
    case (s)
      S_TRICKLE: iset_of = (quarter == '0) ? (SEL_W+1)'(1) : quarter;
      S_CC,
      S_CV:      iset_of = full;
      default:   iset_of = '0;
    endcase
  endfunction

  // Next-state decision: enable, then timeout, then temperature, then normal progress.
  always_comb begin
    st_n     = st_q;
    sel_n    = sel_q;
    flt_n    = flt_q;
    cnt_n    = cnt_q;
    charging = (st_q == S_TRICKLE) || (st_q == S_CC) || (st_q == S_CV);
    temp_ok  = (bus.vtemp >= TMIN_C) && (bus.vtemp <= TMAX_C);
    pre_chg  = (bus.vbat < VPRE_C);
    // Timer runs only while charging; any entry from IDLE/DONE therefore starts at zero.
    tmr_n    = charging ? ((tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1)) : '0;

    if (!bus.en) begin
      st_n  = S_IDLE;
      flt_n = F_NONE;
      tmr_n = '0;
    end else if (charging && (tmr_q == TMR_LAST)) begin
      st_n  = S_FAULT;
      flt_n = F_TIME;
    end else if (bus.adc_valid) begin
      if (st_q != S_FAULT && !temp_ok) begin
        st_n  = S_FAULT;
        flt_n = F_TEMP;
      end else begin
        case (st_q)
          S_IDLE: begin
            sel_n = bus.sel;
            st_n  = pre_chg ? S_TRICKLE : S_CC;
          end
          S_TRICKLE: if (!pre_chg) st_n = S_CC;
          S_CC:      if (bus.vbat >= VFLOAT_C) st_n = S_CV;
          S_CV: begin
            if (bus.ibat < ITERM_C) begin
              if (cnt_q == CNT_LAST) st_n = S_DONE;
              else                   cnt_n = cnt_q + CNT_W'(1);
            end else begin
              cnt_n = '0;
            end
          end
          S_DONE: begin
            if (bus.vbat < VRECHG_C) begin
              sel_n = bus.sel;
              st_n  = pre_chg ? S_TRICKLE : S_CC;
            end
          end
          S_FAULT: begin
            if (flt_q == F_TEMP && temp_ok) begin
              st_n  = S_IDLE;
              flt_n = F_NONE;
            end
          end
          default: st_n = S_IDLE;
        endcase
      end
    end

    // The termination debounce only has meaning inside CV.
    if (st_n != S_CV) cnt_n = '0;
  end

  // State, latches and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= S_IDLE;
      sel_q       <= '0;
      flt_q       <= F_NONE;
      tmr_q       <= '0;
      cnt_q       <= '0;
      bus.iset    <= '0;
      bus.cv_mode <= 1'b0;
      bus.chg_on  <= 1'b0;
      bus.done    <= 1'b0;
      bus.fault   <= F_NONE;
      bus.state   <= S_IDLE;
    end else begin
      st_q        <= st_n;
      sel_q       <= sel_n;
      flt_q       <= flt_n;
      tmr_q       <= tmr_n;
      cnt_q       <= cnt_n;
      bus.iset    <= iset_of(st_n, sel_n);
      bus.cv_mode <= (st_n == S_CV);
      bus.chg_on  <= (st_n == S_TRICKLE) || (st_n == S_CC) || (st_n == S_CV);
      bus.done    <= (st_n == S_DONE);
      bus.fault   <= flt_n;
      bus.state   <= st_n;
    end
  end

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed bench for batcharger_ctrl with a behavioural reference model.
module tb_batcharger_ctrl;
  localparam int TO     = 50;
  localparam int VPRE   = 300;
  localparam int VFLOAT = 840;
  localparam int VRECHG = 800;
  localparam int ITERM  = 20;
  localparam int TMIN   = 100;
  localparam int TMAX   = 900;
  localparam int NTERM  = 4;

  logic clk;
  logic rst;

  batcharger_if #(.ADC_W(10), .SEL_W(4)) bus ();

  batcharger_ctrl #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode plus "clock of charge start" and "run of low-current samples".
  int m_st = 0, m_sel = 0, m_fault = 0, m_low = 0, m_start = 0, cyc = 0;

  // Pending hand-computed expectation, consumed by the compare process.
  int    lit_seq = 0, lit_seen = 0;
  string lit_name;
  int    lit_st, lit_is, lit_cv, lit_chg, lit_dn, lit_fl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_iset(input int st, input int s);
    int full;
    full = s + 1;
    if (st == 1) return (full / 4 < 1) ? 1 : full / 4;
    if (st == 2 || st == 3) return full;
    return 0;
  endfunction

  // Behavioural model updated on every clock (and on reset).
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_st = 0; m_sel = 0; m_fault = 0; m_low = 0;
      end else begin
        bit ok, chg;
        int vb, ib;
        cyc++;
        vb  = int'(bus.vbat);
        ib  = int'(bus.ibat);
        ok  = (int'(bus.vtemp) >= TMIN) && (int'(bus.vtemp) <= TMAX);
        chg = (m_st >= 1 && m_st <= 3);
        if (!bus.en) begin
          m_st = 0; m_fault = 0;
        end else if (chg && (cyc - m_start == TO)) begin
          m_st = 5; m_fault = 2;
        end else if (bus.adc_valid) begin
          if (m_st == 5) begin
            if (m_fault == 1 && ok) begin m_st = 0; m_fault = 0; end
          end else if (!ok) begin
            m_st = 5; m_fault = 1;
          end else if (m_st == 0 || (m_st == 4 && vb < VRECHG)) begin
            m_sel = int'(bus.sel); m_start = cyc; m_st = (vb < VPRE) ? 1 : 2;
          end else if (m_st == 1 && vb >= VPRE) begin
            m_st = 2;
          end else if (m_st == 2 && vb >= VFLOAT) begin
            m_st = 3; m_low = 0;
          end else if (m_st == 3) begin
            m_low = (ib < ITERM) ? m_low + 1 : 0;
            if (m_low == NTERM) m_st = 4;
          end
        end
      end
    end
  end

  // Compare process: DUT vs model every falling edge, plus any pending literal check.
  initial begin
    forever begin
      int e_is, e_cv, e_chg, e_dn;
      @(negedge clk);
      e_is  = exp_iset(m_st, m_sel);
      e_cv  = (m_st == 3) ? 1 : 0;
      e_chg = (m_st >= 1 && m_st <= 3) ? 1 : 0;
      e_dn  = (m_st == 4) ? 1 : 0;
      checks++;
      if (int'(bus.state) != m_st || int'(bus.iset) != e_is || int'(bus.cv_mode) != e_cv ||
          int'(bus.chg_on) != e_chg || int'(bus.done) != e_dn || int'(bus.fault) != m_fault) begin
        errors++;
        $display("FAIL model t=%0t got st=%0d iset=%0d cv=%0d chg=%0d done=%0d fault=%0d exp st=%0d iset=%0d cv=%0d chg=%0d done=%0d fault=%0d",
                 $time, bus.state, bus.iset, bus.cv_mode, bus.chg_on, bus.done, bus.fault,
                 m_st, e_is, e_cv, e_chg, e_dn, m_fault);
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        checks++;
        if (int'(bus.state) != lit_st || int'(bus.iset) != lit_is || int'(bus.cv_mode) != lit_cv ||
            int'(bus.chg_on) != lit_chg || int'(bus.done) != lit_dn || int'(bus.fault) != lit_fl) begin
          errors++;
          $display("FAIL %s got st=%0d iset=%0d cv=%0d chg=%0d done=%0d fault=%0d exp st=%0d iset=%0d cv=%0d chg=%0d done=%0d fault=%0d",
                   lit_name, bus.state, bus.iset, bus.cv_mode, bus.chg_on, bus.done, bus.fault,
                   lit_st, lit_is, lit_cv, lit_chg, lit_dn, lit_fl);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic smp(input int vb, input int ib, input int vt);
    bus.vbat = 10'(vb); bus.ibat = 10'(ib); bus.vtemp = 10'(vt);
    bus.adc_valid = 1'b1;
    @(posedge clk); #2;
    bus.adc_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input int st, input int is, input int cv,
                     input int chg, input int dn, input int fl);
    lit_name = nm; lit_st = st; lit_is = is; lit_cv = cv;
    lit_chg = chg; lit_dn = dn; lit_fl = fl;
    lit_seq++;
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.sel = 4'd0; bus.adc_valid = 1'b0;
    bus.vbat = '0; bus.ibat = '0; bus.vtemp = '0;
    tick(3);
    lit("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1);

    // Start in trickle, then CC, CV and debounced termination.
    bus.en = 1'b1; bus.sel = 4'd3;
    smp(200, 0, 500);  lit("start_trickle", 1, 1, 0, 1, 0, 0);
    smp(350, 0, 500);  lit("to_cc", 2, 4, 0, 1, 0, 0);
    smp(850, 0, 500);  lit("to_cv", 3, 4, 1, 1, 0, 0);
    smp(850, 10, 500); smp(850, 10, 500); smp(850, 30, 500);
    smp(850, 10, 500); smp(850, 10, 500); smp(850, 10, 500);
    lit("term_restart", 3, 4, 1, 1, 0, 0);
    smp(850, 10, 500); lit("to_done", 4, 0, 0, 0, 1, 0);

    // Recharge threshold and sel re-latch; sel ignored while charging.
    smp(810, 0, 500);  lit("no_recharge", 4, 0, 0, 0, 1, 0);
    bus.sel = 4'd7;
    smp(790, 0, 500);  lit("recharge_cc", 2, 8, 0, 1, 0, 0);
    bus.sel = 4'd15;
    smp(500, 0, 500);  lit("sel_ignored", 2, 8, 0, 1, 0, 0);

    // Temperature fault, recovery and window boundaries.
    smp(500, 0, 950);  lit("temp_fault", 5, 0, 0, 0, 0, 1);
    smp(500, 0, 500);  lit("temp_recover", 0, 0, 0, 0, 0, 0);
    smp(500, 0, 100);  lit("tmin_ok", 2, 16, 0, 1, 0, 0);
    smp(500, 0, 900);  lit("tmax_ok", 2, 16, 0, 1, 0, 0);
    smp(500, 0, 99);   lit("below_tmin", 5, 0, 0, 0, 0, 1);
    smp(500, 0, 901);  lit("above_tmax", 5, 0, 0, 0, 0, 1);
    smp(500, 0, 500);  lit("recover2", 0, 0, 0, 0, 0, 0);

    // Safety timeout exactly TO clocks after entering charge.
    bus.sel = 4'd3;
    smp(500, 0, 500);  lit("to_start", 2, 4, 0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) smp(500, 0, 500);
    lit("pre_timeout", 2, 4, 0, 1, 0, 0);
    smp(500, 0, 500);  lit("timeout", 5, 0, 0, 0, 0, 2);
    smp(500, 0, 500);  lit("timeout_latched", 5, 0, 0, 0, 0, 2);
    bus.en = 1'b0;
    tick(1);           lit("en_clears", 0, 0, 0, 0, 0, 0);

    // en=0 mid-CV.
    bus.en = 1'b1;
    smp(850, 0, 500);  smp(850, 0, 500);
    lit("cv_again", 3, 4, 1, 1, 0, 0);
    bus.en = 1'b0;
    tick(1);           lit("en_off_cv", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-CV.
    bus.en = 1'b1;
    smp(850, 0, 500);  smp(850, 0, 500);
    lit("cv_pre_rst", 3, 4, 1, 1, 0, 0);
    smp(850, 10, 500);
    #1 rst = 1'b1;
    lit("async_rst", 0, 0, 0, 0, 0, 0);
    tick(2);
    rst = 1'b0;
    bus.en = 1'b0;
    tick(2);
    lit("after_rst", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
